// File: rtl/teak_action_control_pkg.sv
// Shared register offsets, FSM state types and the default parameter-array depth
// for the teak action controller.
package teak_action_control_pkg;

  localparam int          PARAM_WORDS_DEFAULT = 8;
  localparam logic [31:0] ADDR_CTRL           = 32'h0000_0000;
  localparam logic [31:0] ADDR_CYCLES         = 32'h0000_0008;
  localparam logic [31:0] ADDR_PARAM_BASE     = 32'h0000_0010;

  typedef enum logic [2:0] {A_IDLE, A_GO, A_GORTZ, A_RUN, A_DONE} a_state_t;
  typedef enum logic [1:0] {P_IDLE, P_DATA, P_DRTZ, P_ACK} p_state_t;

endpackage

// File: rtl/teak_action_control_param.sv
// teak_param_server: answers four-phase parameter index requests from the action
// with the latched contents of the kernel parameter register array.
//
// state  | meaning
// P_IDLE | waiting for param_addr_0r
// P_DATA | data latched and presented, param_data_0r high
// P_DRTZ | data taken, waiting for param_data_0a to return low
// P_ACK  | param_addr_0a high, waiting for param_addr_0r to return low
module teak_param_server
  import teak_action_control_pkg::*;
#(
  parameter int PARAM_WORDS = PARAM_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_params [PARAM_WORDS],
  input  logic        i_param_addr_0r,
  input  logic [31:0] i_param_addr,
  output logic        o_param_addr_0a,
  output logic        o_param_data_0r,
  output logic [31:0] o_param_data,
  input  logic        i_param_data_0a
);
  localparam int IDX_W = (PARAM_WORDS > 1) ? $clog2(PARAM_WORDS) : 1;

  p_state_t         r_state;
  p_state_t         w_next;
  logic [31:0]      r_data;
  logic [IDX_W-1:0] w_idx;

  assign w_idx = i_param_addr[IDX_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= P_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      P_IDLE:  if (i_param_addr_0r)  w_next = P_DATA;
      P_DATA:  if (i_param_data_0a)  w_next = P_DRTZ;
      P_DRTZ:  if (!i_param_data_0a) w_next = P_ACK;
      P_ACK:   if (!i_param_addr_0r) w_next = P_IDLE;
      default: w_next = P_IDLE;
    endcase
  end

  always_comb begin
    o_param_data_0r = (r_state == P_DATA);
    o_param_addr_0a = (r_state == P_ACK);
    o_param_data    = r_data;
  end

  // Data is captured once per request so it stays stable through the whole handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_data <= '0;
    else if (r_state == P_IDLE && i_param_addr_0r)
      r_data <= (i_param_addr < 32'(PARAM_WORDS)) ? i_params[w_idx] : '0;
  end

endmodule

// File: rtl/teak_action_control.sv
// AXI-lite controlled action sequencer: CTRL/CYCLES/PARAM registers, four-phase go/done
// channel and a parameter server. Cycle counter built only with TEAK_ACTION_CYCLE_COUNT_EN.
//
// state   | meaning
// A_IDLE  | no action running, start accepted
// A_GO    | go_0r high, waiting for go_0a
// A_GORTZ | go_0a seen, waiting for it to return low
// A_RUN   | action running, waiting for done_0r
// A_DONE  | done_0a high, waiting for done_0r to return low
module teak_action_control
  import teak_action_control_pkg::*;
#(
  parameter int PARAM_WORDS = PARAM_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] s_axi_araddr,
  input  logic [3:0]  s_axi_arcache,
  input  logic [2:0]  s_axi_arprot,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  input  logic [31:0] s_axi_awaddr,
  input  logic [3:0]  s_axi_awcache,
  input  logic [2:0]  s_axi_awprot,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  output logic        go_0r,
  input  logic        go_0a,
  input  logic        done_0r,
  output logic        done_0a,
  input  logic        param_addr_0r,
  input  logic [31:0] param_addr,
  output logic        param_addr_0a,
  output logic        param_data_0r,
  output logic [31:0] param_data,
  input  logic        param_data_0a
);
  localparam int          IDX_W     = (PARAM_WORDS > 1) ? $clog2(PARAM_WORDS) : 1;
  localparam logic [31:0] PARAM_END = ADDR_PARAM_BASE + 32'(4 * PARAM_WORDS);

  a_state_t         r_state;
  a_state_t         w_next;
  logic [31:0]      r_params [PARAM_WORDS];
  logic             r_wr_acc, r_bvalid, r_rd_acc, r_rvalid, r_rd_ctrl, r_done;
  logic [31:0]      r_rdata, w_rdata, w_cycles;
  logic             w_wr_fire, w_rd_fire, w_start, w_wr_param, w_rd_param;
  logic             w_done_set, w_done_clr;
  logic [IDX_W-1:0] w_wr_idx, w_rd_idx;
  logic             w_unused;

  assign w_unused = ^{s_axi_arcache, s_axi_arprot, s_axi_awcache, s_axi_awprot};

  assign w_wr_fire  = r_wr_acc & s_axi_awvalid & s_axi_wvalid;
  assign w_rd_fire  = r_rd_acc & s_axi_arvalid;
  assign w_start    = w_wr_fire && (s_axi_awaddr == ADDR_CTRL) && s_axi_wdata[0];
  assign w_wr_param = w_wr_fire && (r_state == A_IDLE) && (s_axi_awaddr >= ADDR_PARAM_BASE)
                      && (s_axi_awaddr < PARAM_END) && (s_axi_awaddr[1:0] == 2'b00);
  assign w_rd_param = (s_axi_araddr >= ADDR_PARAM_BASE) && (s_axi_araddr < PARAM_END)
                      && (s_axi_araddr[1:0] == 2'b00);
  assign w_wr_idx   = IDX_W'((s_axi_awaddr - ADDR_PARAM_BASE) >> 2);
  assign w_rd_idx   = IDX_W'((s_axi_araddr - ADDR_PARAM_BASE) >> 2);
  assign w_done_set = (r_state == A_DONE) && !done_0r;
  assign w_done_clr = r_rvalid && s_axi_rready && r_rd_ctrl;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= A_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      A_IDLE:  if (w_start)  w_next = A_GO;
      A_GO:    if (go_0a)    w_next = A_GORTZ;
      A_GORTZ: if (!go_0a)   w_next = A_RUN;
      A_RUN:   if (done_0r)  w_next = A_DONE;
      A_DONE:  if (!done_0r) w_next = A_IDLE;
      default: w_next = A_IDLE;
    endcase
  end

  always_comb begin
    go_0r   = (r_state == A_GO);
    done_0a = (r_state == A_DONE);
  end

  assign s_axi_awready = r_wr_acc;
  assign s_axi_wready  = r_wr_acc;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_arready = r_rd_acc;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = 2'b00;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_acc <= 1'b0;
      r_bvalid <= 1'b0;
    end else begin
      r_wr_acc <= !r_wr_acc && !r_bvalid && s_axi_awvalid && s_axi_wvalid;
      if (w_wr_fire)                   r_bvalid <= 1'b1;
      else if (r_bvalid && s_axi_bready) r_bvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PARAM_WORDS; i++) r_params[i] <= '0;
    end else if (w_wr_param) begin
      for (int b = 0; b < 4; b++)
        if (s_axi_wstrb[b]) r_params[w_wr_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
    end
  end

  always_comb begin
    w_rdata = '0;
    if (s_axi_araddr == ADDR_CTRL)        w_rdata = {29'd0, (r_state == A_IDLE), r_done, 1'b0};
    else if (s_axi_araddr == ADDR_CYCLES) w_rdata = w_cycles;
    else if (w_rd_param)                  w_rdata = r_params[w_rd_idx];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_acc  <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rd_ctrl <= 1'b0;
    end else begin
      r_rd_acc <= !r_rd_acc && !r_rvalid && s_axi_arvalid;
      if (w_rd_fire) begin
        r_rvalid  <= 1'b1;
        r_rdata   <= w_rdata;
        r_rd_ctrl <= (s_axi_araddr == ADDR_CTRL);
      end else if (r_rvalid && s_axi_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  // A completion landing on the same edge as a clearing CTRL read keeps done set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          r_done <= 1'b0;
    else if (w_done_set) r_done <= 1'b1;
    else if (w_done_clr) r_done <= 1'b0;
  end

`ifdef TEAK_ACTION_CYCLE_COUNT_EN
  logic [31:0] r_cycles;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cycles <= '0;
    end else if (r_state == A_IDLE) begin
      if (w_next != A_IDLE) r_cycles <= '0;
    end else if (r_cycles != 32'hFFFF_FFFF) begin
      r_cycles <= r_cycles + 32'd1;
    end
  end
  assign w_cycles = r_cycles;
`else
  assign w_cycles = '0;
`endif

  teak_param_server #(.PARAM_WORDS(PARAM_WORDS)) u_param_server (
    .clk             (clk),
    .reset           (reset),
    .i_params        (r_params),
    .i_param_addr_0r (param_addr_0r),
    .i_param_addr    (param_addr),
    .o_param_addr_0a (param_addr_0a),
    .o_param_data_0r (param_data_0r),
    .o_param_data    (param_data),
    .i_param_data_0a (param_data_0a)
  );

endmodule

// File: tb/tb_teak_action_control.sv
// Scoreboard bench for teak_action_control: AXI responses are checked by a monitor
// against queued expectations; handshake channels are checked inline.
module tb_teak_action_control;
  import teak_action_control_pkg::*;

  typedef struct {
    string       nm;
    logic [31:0] lo;
    logic [31:0] hi;
  } rd_exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] s_axi_araddr = '0, s_axi_awaddr = '0, s_axi_wdata = '0, s_axi_rdata;
  logic [3:0]  s_axi_arcache = '0, s_axi_awcache = '0, s_axi_wstrb = '0;
  logic [2:0]  s_axi_arprot = '0, s_axi_awprot = '0;
  logic        s_axi_arvalid = 1'b0, s_axi_awvalid = 1'b0, s_axi_wvalid = 1'b0;
  logic        s_axi_rready = 1'b1, s_axi_bready = 1'b1;
  logic        s_axi_arready, s_axi_rvalid, s_axi_awready, s_axi_wready, s_axi_bvalid;
  logic [1:0]  s_axi_rresp, s_axi_bresp;
  logic        go_0r, go_0a = 1'b0, done_0r = 1'b0, done_0a;
  logic        param_addr_0r = 1'b0, param_addr_0a, param_data_0r, param_data_0a = 1'b0;
  logic [31:0] param_addr = '0, param_data;

  int      checks = 0;
  int      failures = 0;
  int      cyc = 0;
  rd_exp_t rq[$];
  string   bq[$];
  rd_exp_t m_e;
  string   m_s;

  teak_action_control #(.PARAM_WORDS(8)) dut (
    .clk(clk), .reset(reset),
    .s_axi_araddr(s_axi_araddr), .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .go_0r(go_0r), .go_0a(go_0a), .done_0r(done_0r), .done_0a(done_0a),
    .param_addr_0r(param_addr_0r), .param_addr(param_addr), .param_addr_0a(param_addr_0a),
    .param_data_0r(param_data_0r), .param_data(param_data), .param_data_0a(param_data_0a)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT completes a read or write response.
  always @(negedge clk) begin
    if (reset) begin
      if (s_axi_rvalid && s_axi_rready) begin
        if (rq.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
        else begin
          m_e = rq.pop_front();
          checks++;
          if (s_axi_rdata < m_e.lo || s_axi_rdata > m_e.hi) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h..0x%08h", m_e.nm, s_axi_rdata, m_e.lo, m_e.hi);
          end
          check({m_e.nm, "_rresp"}, {30'd0, s_axi_rresp}, 32'd0);
        end
      end
      if (s_axi_bvalid && s_axi_bready) begin
        if (bq.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
        else begin
          m_s = bq.pop_front();
          check({m_s, "_bresp"}, {30'd0, s_axi_bresp}, 32'd0);
        end
      end
    end
  end

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input string nm);
    int n = 0;
    bq.push_back(nm);
    @(negedge clk);
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    while (!s_axi_awready && n < 20) begin @(negedge clk); n++; end
    if (!s_axi_awready) begin
      check({nm, "_aw_timeout"}, 32'd0, 32'd1);
      void'(bq.pop_back());
    end else begin
      @(posedge clk);
    end
    #1 s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    @(negedge clk);
  endtask

  task automatic axi_read(input logic [31:0] a, input string nm, input logic [31:0] lo, input logic [31:0] hi);
    rd_exp_t e;
    int n = 0;
    e.nm = nm; e.lo = lo; e.hi = hi;
    rq.push_back(e);
    @(negedge clk);
    s_axi_araddr = a; s_axi_arvalid = 1'b1;
    while (!s_axi_arready && n < 20) begin @(negedge clk); n++; end
    if (!s_axi_arready) begin
      check({nm, "_ar_timeout"}, 32'd0, 32'd1);
      void'(rq.pop_back());
    end else begin
      @(posedge clk);
    end
    #1 s_axi_arvalid = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic sig(input int s);
    case (s)
      0: return go_0r;
      1: return done_0a;
      2: return param_data_0r;
      3: return param_addr_0a;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_sig(input int s, input logic v, input int lim, input string nm);
    int n = 0;
    while (sig(s) !== v && n < lim) begin @(negedge clk); n++; end
    check(nm, {31'd0, sig(s)}, {31'd0, v});
  endtask

  task automatic do_go();
    go_0a = 1'b1;
    wait_sig(0, 1'b0, 10, "go_fall");
    go_0a = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_done();
    done_0r = 1'b1;
    wait_sig(1, 1'b1, 10, "done_0a_rise");
    done_0r = 1'b0;
    wait_sig(1, 1'b0, 10, "done_0a_fall");
  endtask

  task automatic param_req(input logic [31:0] idx, input logic [31:0] exp, input string nm);
    param_addr = idx; param_addr_0r = 1'b1;
    wait_sig(2, 1'b1, 10, {nm, "_0r_rise"});
    check({nm, "_data"}, param_data, exp);
    param_data_0a = 1'b1;
    wait_sig(2, 1'b0, 10, {nm, "_0r_fall"});
    check({nm, "_stable"}, param_data, exp);
    param_data_0a = 1'b0;
    wait_sig(3, 1'b1, 10, {nm, "_addr_0a_rise"});
    check({nm, "_stable2"}, param_data, exp);
    param_addr_0r = 1'b0;
    wait_sig(3, 1'b0, 10, {nm, "_addr_0a_fall"});
  endtask

  task automatic check_outs_zero(input string nm);
    check({nm, "_hs"}, {23'd0, go_0r, done_0a, param_addr_0a, param_data_0r, s_axi_awready,
                        s_axi_wready, s_axi_arready, s_axi_rvalid, s_axi_bvalid}, 32'd0);
    check({nm, "_pdata"}, param_data, 32'd0);
    check({nm, "_rdata"}, s_axi_rdata, 32'd0);
  endtask

  initial begin
    int t0, t1, n;
    #1;
    check_outs_zero("reset");
    repeat (3) @(negedge clk);
    reset = 1'b1;

    axi_read(ADDR_CTRL, "ctrl_reset", 32'h4, 32'h4);
    axi_read(ADDR_CYCLES, "cycles_reset", 32'h0, 32'h0);
    axi_read(ADDR_PARAM_BASE + 8, "param2_reset", 32'h0, 32'h0);

    axi_write(ADDR_PARAM_BASE + 8, 32'hDEADBEEF, 4'hF, "wr_param2");
    axi_write(ADDR_PARAM_BASE + 12, 32'h11223344, 4'h5, "wr_param3_strb");
    axi_write(32'h0000_0200, 32'hFFFF_FFFF, 4'hF, "wr_unmapped");
    axi_read(ADDR_PARAM_BASE + 8, "param2_rb", 32'hDEADBEEF, 32'hDEADBEEF);
    axi_read(ADDR_PARAM_BASE + 12, "param3_strb", 32'h00220044, 32'h00220044);
    axi_read(32'h0000_000C, "rd_unmapped", 32'h0, 32'h0);
    axi_read(ADDR_PARAM_BASE + 32, "rd_param_oor", 32'h0, 32'h0);

    // Start the action and drive it through the go handshake and parameter fetches.
    axi_write(ADDR_CTRL, 32'h1, 4'hF, "wr_start");
    t0 = cyc;
    wait_sig(0, 1'b1, 2, "go_rise");
    axi_read(ADDR_CTRL, "ctrl_busy", 32'h0, 32'h0);
    do_go();
    param_req(32'd2, 32'hDEADBEEF, "preq2");
    param_req(32'd3, 32'h00220044, "preq3");
    param_req(32'd70, 32'h0, "preq70");

    axi_write(ADDR_CTRL, 32'h1, 4'hF, "wr_start_run");
    axi_write(ADDR_PARAM_BASE, 32'h5, 4'hF, "wr_param0_run");
    n = 0;
    repeat (4) begin @(negedge clk); n += int'(go_0r); end
    check("no_second_go", n, 0);
    axi_read(ADDR_PARAM_BASE, "param0_run", 32'h0, 32'h0);

    while (cyc - t0 < 96) @(negedge clk);
    do_done();
    t1 = cyc;
    axi_read(ADDR_CTRL, "ctrl_done", 32'h6, 32'h6);
    axi_read(ADDR_CTRL, "ctrl_done_clr", 32'h4, 32'h4);
`ifdef TEAK_ACTION_CYCLE_COUNT_EN
    axi_read(ADDR_CYCLES, "cycles_run", 32'(t1 - t0 - 2), 32'(t1 - t0 + 2));
`else
    axi_read(ADDR_CYCLES, "cycles_run", 32'h0, 32'h0);
`endif

    // Reset while go_0r is high.
    axi_write(ADDR_CTRL, 32'h1, 4'hF, "wr_start2");
    wait_sig(0, 1'b1, 2, "go_rise2");
    @(negedge clk);
    reset = 1'b0;
    #1 check_outs_zero("rst_go");
    @(negedge clk);
    reset = 1'b1;
    axi_read(ADDR_CTRL, "ctrl_after_rst", 32'h4, 32'h4);
    axi_read(ADDR_PARAM_BASE + 8, "param2_after_rst", 32'h0, 32'h0);

    // Reset while the parameter server is presenting data.
    axi_write(ADDR_PARAM_BASE + 4, 32'hCAFE0001, 4'hF, "wr_param1");
    axi_write(ADDR_CTRL, 32'h1, 4'hF, "wr_start3");
    wait_sig(0, 1'b1, 2, "go_rise3");
    do_go();
    param_addr = 32'd1; param_addr_0r = 1'b1;
    wait_sig(2, 1'b1, 10, "pdata_rise_pre_rst");
    check("pdata_pre_rst", param_data, 32'hCAFE0001);
    reset = 1'b0;
    #1 check_outs_zero("rst_pdata");
    param_addr_0r = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    axi_write(ADDR_CTRL, 32'h1, 4'hF, "wr_start4");
    wait_sig(0, 1'b1, 2, "go_rise4");
    do_go();
    do_done();
    axi_read(ADDR_CTRL, "ctrl_done2", 32'h6, 32'h6);

    n = 0;
    while ((rq.size() != 0 || bq.size() != 0) && n < 20) begin @(negedge clk); n++; end
    check("sb_drain", rq.size() + bq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/teak_action_control.md
TEAK_ACTION_CONTROL -- requirements
Module: teak_action_control

Interface
REQ-001 The block SHALL have parameter PARAM_WORDS, default 8, giving the number of 32-bit kernel parameter registers (range 1..64).
REQ-002 The block SHALL have port clk, input, 1, the single clock.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have AXI-lite slave ports s_axi_ar*/r*/aw*/w*/b*, with 32-bit addr/data, 4-bit wstrb, 2-bit resp; arcache/arprot/awcache/awprot are unused.
REQ-005 The block SHALL have ports go_0r (out, 1) and go_0a (in, 1), the four-phase action start channel.
REQ-006 The block SHALL have ports done_0r (in, 1) and done_0a (out, 1), the four-phase action completion channel.
REQ-007 The block SHALL have ports param_addr_0r (in, 1), param_addr (in, 32) and param_addr_0a (out, 1), the parameter index request.
REQ-008 The block SHALL have ports param_data_0r (out, 1), param_data (out, 32) and param_data_0a (in, 1), the parameter data reply.

Function
REQ-009 Register map SHALL be: 0x00 CTRL (bit0 start, write-1 only; bit1 done, sticky, clear-on-read; bit2 idle, read-only); 0x08 CYCLES; 0x10+4*i PARAM[i].
REQ-010 Action FSM SHALL use states A_IDLE, A_GO, A_GORTZ, A_RUN, A_DONE.
- A_IDLE -> A_GO on a CTRL write with bit0=1; go_0r=1.
- A_GO -> A_GORTZ on go_0a=1; go_0r=0.
- A_GORTZ -> A_RUN on go_0a=0.
- A_RUN -> A_DONE on done_0r=1; done_0a=1.
- A_DONE -> A_IDLE on done_0r=0; done_0a=0 and done bit set.
REQ-011 The idle bit SHALL be 1 only in A_IDLE; a start write outside A_IDLE SHALL be ignored.
REQ-012 If done is set and a CTRL read completes in the same cycle, done SHALL remain set (set wins).
REQ-013 The AXI-lite write SHALL accept only when awvalid&wvalid are both high: awready=wready=1 for one cycle, then bvalid=1, bresp=0, held until bready; one transaction outstanding at a time.
REQ-014 The AXI-lite read SHALL assert arready for one cycle after arvalid, then rvalid=1, rresp=0, with rdata registered and held until rready.
REQ-015 PARAM writes SHALL honour wstrb per byte and SHALL be discarded, still with OKAY, while not in A_IDLE.
REQ-016 Reads of unmapped or out-of-range addresses SHALL return 0 with OKAY; writes to them SHALL be discarded.
REQ-017 A read and a write to the same register in the same cycle SHALL return the pre-write value.
REQ-018 Param server FSM SHALL use states P_IDLE, P_DATA, P_DRTZ, P_ACK.
- P_IDLE -> P_DATA on param_addr_0r=1; index=param_addr latched, param_data driven, param_data_0r=1.
- P_DATA -> P_DRTZ on param_data_0a=1; param_data_0r=0.
- P_DRTZ -> P_ACK on param_data_0a=0; param_addr_0a=1.
- P_ACK -> P_IDLE on param_addr_0r=0; param_addr_0a=0.
REQ-019 A param index >= PARAM_WORDS SHALL return data 0.
REQ-020 param_data SHALL stay stable from P_DATA until P_IDLE.

Reset
REQ-021 Asserting reset SHALL asynchronously force A_IDLE and P_IDLE, all PARAM=0, done=0, CYCLES=0, and all outputs 0 (idle reads 1).
REQ-022 Reset mid-handshake SHALL abandon the transaction with no completion, response or done record.

Configuration
REQ-023 With TEAK_ACTION_CYCLE_COUNT_EN defined, CYCLES SHALL clear on leaving A_IDLE, increment each cycle outside A_IDLE, saturate at 0xFFFFFFFF and hold after completion; without it, CYCLES SHALL read 0 and the counter SHALL be absent.

Structure
REQ-024 Package teak_action_control_pkg SHALL hold the register offsets, the action and param state enum typedefs and the PARAM_WORDS default.
REQ-025 The param FSM SHALL be sub-module teak_param_server, fed by the parameter register array.

Verification
REQ-026 Write PARAM[2]=0xDEADBEEF, then CTRL=1 -> go_0r rises within 2 cycles; idle reads 0.
REQ-027 Action requests index 2 -> param_data=0xDEADBEEF; full four-phase completes; index 70 -> 0.
REQ-028 Action done_0r=1 then 0 -> done_0a pulses; CTRL read returns 0x6 then 0x4.
REQ-029 CTRL=1 and PARAM[0]=5 written while in A_RUN -> no second go and PARAM[0] unchanged, both OKAY.
REQ-030 With the macro defined and a 100-cycle run, CYCLES reads 100 ±2; without the macro it reads 0.
REQ-031 reset asserted in A_GO and in P_DATA -> all outputs 0 immediately; next start works normally.
